// File: rtl/i2s_serializer.sv
`timescale 1ns/1ps
// I2S transmitter: synchronizes the divider bit clock, counts 2*SAMPLE_W slots and shifts a buffered stereo pair out MSB first.
// One-entry sample buffer with valid/ready; an empty buffer at frame load sends silence and raises a sticky underrun.
module i2s_serializer #(
   parameter int SAMPLE_W    = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                baseClk,
   input  logic                resetN,
   input  logic                dividedClk,
   input  logic [SAMPLE_W-1:0] sampleL,
   input  logic [SAMPLE_W-1:0] sampleR,
   input  logic                sampleValid,
   output logic                sampleReady,
   output logic                bclk,
   output logic                lrclk,
   output logic                sdata,
   output logic                frameStart,
   output logic                underrun,
   input  logic                underrunClr
);
   localparam int FRAME_W = 2 * SAMPLE_W;
   localparam int CNT_W   = $clog2(FRAME_W);
   localparam logic [CNT_W-1:0] LAST_SLOT  = CNT_W'(FRAME_W - 1);
   localparam logic [CNT_W-1:0] LOAD_SLOT  = CNT_W'(1);
   localparam logic [CNT_W-1:0] RIGHT_SLOT = CNT_W'(SAMPLE_W);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_dcD;
   logic                   r_bclk;
   logic                   r_lrclk;
   logic                   r_frameStart;
   logic                   r_underrun;
   logic                   r_bufValid;
   logic [CNT_W-1:0]       r_bitCnt;
   logic [FRAME_W-1:0]     r_shift;
   logic [SAMPLE_W-1:0]    r_bufL;
   logic [SAMPLE_W-1:0]    r_bufR;

   logic                   w_dcS;
   logic                   w_fallEdge;
   logic                   w_load;
   logic                   w_accept;
   logic [CNT_W-1:0]       w_nextCnt;

   assign w_dcS      = r_sync[SYNC_STAGES-1];
   assign w_fallEdge = r_dcD & ~w_dcS;
   assign w_nextCnt  = (r_bitCnt == LAST_SLOT) ? '0 : r_bitCnt + 1'b1;
   assign w_load     = w_fallEdge && (w_nextCnt == LOAD_SLOT);
   assign w_accept   = sampleValid && !r_bufValid;

   // bclk is a registered copy of the synchronized clock so it changes on the same edge as lrclk/sdata
   always_ff @(posedge baseClk) begin
      if (!resetN) begin
         r_sync <= '0;
         r_dcD  <= 1'b0;
         r_bclk <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], dividedClk};
         r_dcD  <= w_dcS;
         r_bclk <= w_dcS;
      end
   end

   always_ff @(posedge baseClk) begin
      if (!resetN) begin
         r_bitCnt     <= LAST_SLOT;
         r_lrclk      <= 1'b0;
         r_frameStart <= 1'b0;
      end else begin
         r_frameStart <= w_fallEdge && (w_nextCnt == '0);
         if (w_fallEdge) begin
            r_bitCnt <= w_nextCnt;
            r_lrclk  <= (w_nextCnt >= RIGHT_SLOT);
         end
      end
   end

   // Loading at slot 1 rather than slot 0 gives the one-bit delay after each lrclk transition
   always_ff @(posedge baseClk) begin
      if (!resetN) begin
         r_shift <= '0;
      end else if (w_load) begin
         r_shift <= r_bufValid ? {r_bufL, r_bufR} : '0;
      end else if (w_fallEdge) begin
         r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
      end
   end

   // A same-cycle accept refills the buffer for the next frame; the load only sees the old content
   always_ff @(posedge baseClk) begin
      if (!resetN) begin
         r_bufValid <= 1'b0;
         r_bufL     <= '0;
         r_bufR     <= '0;
      end else begin
         if (w_load) begin
            r_bufValid <= 1'b0;
         end
         if (w_accept) begin
            r_bufValid <= 1'b1;
            r_bufL     <= sampleL;
            r_bufR     <= sampleR;
         end
      end
   end

   always_ff @(posedge baseClk) begin
      if (!resetN) begin
         r_underrun <= 1'b0;
      end else begin
         if (underrunClr) begin
            r_underrun <= 1'b0;
         end
         if (w_load && !r_bufValid) begin
            r_underrun <= 1'b1;
         end
      end
   end

   assign sampleReady = ~r_bufValid;
   assign bclk        = r_bclk;
   assign lrclk       = r_lrclk;
   assign sdata       = r_shift[FRAME_W-1];
   assign frameStart  = r_frameStart;
   assign underrun    = r_underrun;

endmodule

// File: doc/i2s_serializer.md
Name: i2s_serializer

Overview:
- Downstream consumer of the clock divider output. Takes the divider's `dividedClk` as a data input and samples it in the `baseClk` domain.
- Turns parallel stereo audio samples into a standard I2S serial stream: `bclk`, `lrclk` and `sdata` toward the codec.
- Provides a one-entry sample buffer with a valid/ready handshake toward the audio processing core.

Parameters:
- SAMPLE_W, 16, bits per channel sample (two's complement, sent MSB first).
- SYNC_STAGES, 2, synchronizer flops on `dividedClk` (minimum 2).

Ports:
- baseClk  input  1  system clock; all logic on its rising edge
- resetN  input  1  synchronous active-low reset
- dividedClk  input  1  bit-clock source from the clock divider; asynchronous to the register timing, so it is synchronized
- sampleL  input  SAMPLE_W  left-channel sample
- sampleR  input  SAMPLE_W  right-channel sample
- sampleValid  input  1  sampleL/sampleR are valid
- sampleReady  output  1  buffer empty; a sample pair is accepted when sampleValid and sampleReady are both high
- bclk  output  1  I2S bit clock
- lrclk  output  1  word select: 0 = left, 1 = right
- sdata  output  1  I2S serial data
- frameStart  output  1  one-cycle pulse when slot 0 begins
- underrun  output  1  sticky flag: a frame was loaded with no buffered sample
- underrunClr  input  1  clears underrun

Behaviour:
- All registers use the synchronous active-low reset, `resetN`, in the `baseClk` domain.
- Reset values:
  - synchronizer flops and edge-history flop: 0
  - bclk, lrclk, sdata, frameStart, underrun: 0
  - bitCnt = 2*SAMPLE_W-1
  - shift register: 0
  - bufValid: 0, so sampleReady = 1
- Synchronization:
  - dividedClk passes through SYNC_STAGES flops to give dcS; dcD is dcS delayed by one cycle.
  - fallEdge = dcD & ~dcS; riseEdge = ~dcD & dcS.
  - No other logic uses dividedClk directly.
- bclk is a register loaded with dcS every cycle. It therefore toggles in the same cycle that sdata and lrclk update, and sdata is stable across every bclk rising edge.
- Slot counter (bitCnt, width clog2(2*SAMPLE_W)):
  - Advances only on fallEdge, wrapping 2*SAMPLE_W-1 -> 0.
  - The first fallEdge after reset enters slot 0.
- lrclk is registered on fallEdge: 0 for slots 0..SAMPLE_W-1, 1 for slots SAMPLE_W..2*SAMPLE_W-1.
- frameStart pulses for exactly one cycle, on the fallEdge cycle that enters slot 0.
- Frame load:
  - On the fallEdge entering slot 1, the 2*SAMPLE_W shift register loads {bufL, bufR}.
  - If bufValid = 0 it loads all zeros and sets underrun.
  - The load clears bufValid.
- Shifting:
  - On every other fallEdge the register shifts left by one; sdata = shift MSB.
  - Left MSB appears in slot 1, left LSB in slot SAMPLE_W.
  - Right MSB appears in slot SAMPLE_W+1, right LSB in slot 0 of the following frame.
  - Result: standard I2S one-bit delay after each lrclk transition.
- Handshake:
  - sampleReady = ~bufValid (combinational).
  - On accept, bufL/bufR capture the inputs and bufValid is set.
  - An accept in the same cycle as a frame load writes the buffer for the next frame. The load uses only the prior buffer content (empty -> zeros + underrun); it never uses the incoming sample.
  - sampleValid while not ready: the inputs are ignored and must be held by the producer.
- underrun: set by a zero-load, cleared by underrunClr. If set and clear occur in the same cycle, set wins.
- Latency: an accepted pair starts serializing on the first slot-1 fallEdge after acceptance.
- dividedClk stalled (no edges): all outputs hold; the buffer still accepts one pair.
- Reset mid-frame: all state returns to reset values on the next baseClk edge. The first post-reset fallEdge restarts at slot 0 with no partial word emitted.
- Supported range: dividedClk high and low phases each last at least SYNC_STAGES+1 baseClk cycles. Behaviour is undefined below that.

Test Plan:
- Reset, then SAMPLE_W=16 and dividedClk period 8 baseClk cycles (4 high / 4 low), no samples offered -> bclk period 8 cycles; lrclk toggles every 16 bclk periods; sdata = 0; underrun rises at the first slot-1 load; sampleReady = 1 throughout.
- Offer L=16'hA5C3, R=16'h8001 before the first slot 1 -> sampleReady drops the cycle after accept. Sampling sdata on bclk rising edges gives the 32-bit pattern A5C38001 in slots 1..31 then 0 of the next frame; lrclk is 0 during slots 0..15.
- Offer a back-to-back stream: 3 frames L=16'h0001*k, R=~L, each presented when ready -> every frame is decoded correctly; no underrun after the first loaded frame; sampleReady re-asserts exactly one cycle after each slot-1 load.
- Drive sampleValid on the exact slot-1 load cycle with an empty buffer -> that frame is all zeros and underrun sets; the offered pair is transmitted in the next frame.
- Assert underrunClr on the same cycle as a new underrun set -> underrun stays 1. Assert underrunClr alone -> 0 on the next cycle.
- Assert resetN = 0 for 2 cycles at slot 20 -> outputs are zero the cycle after reset is sampled; sampleReady = 1; the next fallEdge produces frameStart and lrclk = 0; no residual bits from the aborted word appear.
